// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with an enable-gated prescaler.
// Q[7:4] is the tens digit and Q[3:0] is the ones digit. Q always holds
// legal BCD because only checked loads and BCD steps can change it.
// Tick is combinational so that Q updates on the same edge as the step.
module bcd_counter_2digit #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       En,
    input  logic       Up,
    input  logic       Load,
    input  logic [7:0] D,
    output logic [7:0] Q,
    output logic       Tick,
    output logic       Wrap,
    output logic       LoadErr
);

    // TICK_DIV=1 still needs a 1-bit prescaler. That bit never leaves 0.
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic          atTerm;
    logic          loadValid;
    logic          wrapNext;
    logic [3:0]    onesNext;
    logic [3:0]    tensNext;

    assign atTerm    = (prescaler == TERM);
    assign Tick      = En & atTerm & ~Load & ~Reset;
    assign loadValid = (D[7:4] <= 4'd9) && (D[3:0] <= 4'd9);

    // Next BCD value for one step in the current direction, with the rollover flag.
    always_comb begin
        onesNext = Q[3:0];
        tensNext = Q[7:4];
        wrapNext = 1'b0;
        if (Up) begin
            if (Q[3:0] >= 4'd9) begin
                onesNext = 4'd0;
                if (Q[7:4] >= 4'd9) begin
                    tensNext = 4'd0;
                    wrapNext = 1'b1;
                end else begin
                    tensNext = Q[7:4] + 4'd1;
                end
            end else begin
                onesNext = Q[3:0] + 4'd1;
            end
        end else begin
            if (Q[3:0] == 4'd0) begin
                onesNext = 4'd9;
                if (Q[7:4] == 4'd0) begin
                    tensNext = 4'd9;
                    wrapNext = 1'b1;
                end else begin
                    tensNext = Q[7:4] - 4'd1;
                end
            end else begin
                onesNext = Q[3:0] - 4'd1;
            end
        end
    end

    // Prescaler: any load restarts the period; a low enable freezes the phase.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prescaler <= '0;
        end else if (Load) begin
            prescaler <= '0;
        end else if (En) begin
            if (atTerm) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Counter value: a checked load wins over a step, and a rejected load holds Q.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= 8'h00;
        end else if (Load) begin
            if (loadValid) begin
                Q <= D;
            end
        end else if (Tick) begin
            Q <= {tensNext, onesNext};
        end
    end

    // Wrap pulses for one cycle after a rollover step. Tick is already low during a load.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Wrap <= 1'b0;
        end else begin
            Wrap <= Tick & wrapNext;
        end
    end

    // Sticky flag for a rejected load. It clears only on a good load or on reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            LoadErr <= 1'b0;
        end else if (Load) begin
            LoadErr <= ~loadValid;
        end
    end

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Testbench for bcd_counter_2digit. Two copies run side by side, one with
// TICK_DIV=4 and one with TICK_DIV=1. Both get the same inputs.
// The reference model treats the count as an integer 0..99 that steps
// modulo 100, and the prescaler as a modulo-TICK_DIV phase.
module tb_bcd_counter_2digit;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] d;

    logic [7:0] q4, q1;
    logic       tick4, tick1;
    logic       wrap4, wrap1;
    logic       err4, err1;

    int testCount = 0;
    int failCount = 0;

    int mVal [2];
    int mPre [2];
    bit mWrap[2];
    bit mErr [2];
    int divOf[2] = '{4, 1};

    always #5 clock = ~clock;

    bcd_counter_2digit #(.TICK_DIV(4)) dut4 (
        .Clock(clock), .Reset(reset), .En(en), .Up(up), .Load(load), .D(d),
        .Q(q4), .Tick(tick4), .Wrap(wrap4), .LoadErr(err4)
    );

    bcd_counter_2digit #(.TICK_DIV(1)) dut1 (
        .Clock(clock), .Reset(reset), .En(en), .Up(up), .Load(load), .D(d),
        .Q(q1), .Tick(tick1), .Wrap(wrap1), .LoadErr(err1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] toBcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Drives one cycle on both copies. Tick is checked before the edge.
    // Q, Wrap and LoadErr are checked after it.
    task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l, input logic [7:0] dv);
        bit expTick[2];
        bit dValid;
        int oldVal;
        @(negedge clock);
        reset = r;
        en    = e;
        up    = u;
        load  = l;
        d     = dv;
        #1;
        for (int k = 0; k < 2; k++)
            expTick[k] = e && !l && !r && (mPre[k] == divOf[k] - 1);
        checkOutput("tick4", 32'(tick4), 32'(expTick[0]));
        checkOutput("tick1", 32'(tick1), 32'(expTick[1]));
        @(posedge clock);
        dValid = (dv[7:4] <= 4'd9) && (dv[3:0] <= 4'd9);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mVal[k] = 0;  mPre[k] = 0;  mWrap[k] = 0;  mErr[k] = 0;
            end else if (l) begin
                mPre[k]  = 0;
                mWrap[k] = 0;
                if (dValid) begin
                    mVal[k] = int'(dv[7:4]) * 10 + int'(dv[3:0]);
                    mErr[k] = 0;
                end else begin
                    mErr[k] = 1;
                end
            end else begin
                mWrap[k] = 0;
                if (e) begin
                    if (expTick[k]) begin
                        oldVal   = mVal[k];
                        mVal[k]  = u ? (oldVal + 1) % 100 : (oldVal + 99) % 100;
                        mWrap[k] = u ? (oldVal == 99) : (oldVal == 0);
                    end
                    mPre[k] = (mPre[k] + 1) % divOf[k];
                end
            end
        end
        #1;
        checkOutput("q4",    32'(q4),    32'(toBcd(mVal[0])));
        checkOutput("wrap4", 32'(wrap4), 32'(mWrap[0]));
        checkOutput("err4",  32'(err4),  32'(mErr[0]));
        checkOutput("q1",    32'(q1),    32'(toBcd(mVal[1])));
        checkOutput("wrap1", 32'(wrap1), 32'(mWrap[1]));
        checkOutput("err1",  32'(err1),  32'(mErr[1]));
    endtask

    // Directed scenarios first, then a randomized run against the model.
    initial begin
        bit rndUp;
        logic [7:0] rndD;
        for (int k = 0; k < 2; k++) begin
            mVal[k] = 0;  mPre[k] = 0;  mWrap[k] = 0;  mErr[k] = 0;
        end

        applyStimulus(1, 1, 1, 1, 8'hFF);
        applyStimulus(1, 0, 1, 0, 8'h00);

        for (int i = 0; i < 40; i++) applyStimulus(0, 1, 1, 0, 8'h00);

        applyStimulus(0, 1, 1, 1, 8'h98);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 1, 0, 8'h00);

        applyStimulus(0, 1, 0, 1, 8'h00);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 0, 8'h00);

        applyStimulus(0, 0, 1, 1, 8'h42);
        applyStimulus(0, 0, 1, 1, 8'h4A);
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 1, 8'hA3);
        applyStimulus(0, 0, 1, 1, 8'h37);
        applyStimulus(0, 0, 1, 0, 8'h00);

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 1, 8'h55);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 8'h00);

        applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(1, 1, 1, 0, 8'h00);
        applyStimulus(1, 1, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);

        rndUp = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) rndUp = ~rndUp;
            if ($urandom_range(0, 1) == 0)
                rndD = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                rndD = 8'($urandom);
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 3) != 0,
                          rndUp,
                          $urandom_range(0, 11) == 0,
                          rndD);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_counter_2digit.md
BCD_COUNTER_2DIGIT -- requirements
Module: bcd_counter_2digit

Interface
REQ-001 Parameter TICK_DIV, default 50000000, SHALL set the number of enabled clock cycles per count step (legal range 1..2^26).
REQ-002 Clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 En  input  1  SHALL be the count enable; prescaler and counter hold while low.
REQ-005 Up  input  1  SHALL be the direction select: 1 = count up, 0 = count down.
REQ-006 Load  input  1  SHALL be the synchronous load strobe for D.
REQ-007 D  input  8  SHALL be the load value: D[7:4] tens digit, D[3:0] ones digit, BCD.
REQ-008 Q  output  8  SHALL be the counter value: Q[7:4] tens, Q[3:0] ones; drives the two-digit display decoder directly.
REQ-009 Tick  output  1  SHALL be the prescaler step pulse, high for one cycle.
REQ-010 Wrap  output  1  SHALL be the one-cycle pulse on 99->00 (up) or 00->99 (down).
REQ-011 LoadErr  output  1  SHALL be the sticky flag for a rejected non-BCD load.

Function
REQ-012 Prescaler counter SHALL count 0..TICK_DIV-1 while En=1, return to 0 after TICK_DIV-1, and hold while En=0.
REQ-013 Tick SHALL be combinational: Tick = En AND (prescaler == TICK_DIV-1) AND NOT Load AND NOT Reset.
REQ-014 With TICK_DIV=1, Tick SHALL be high on every cycle with En=1, Load=0 and Reset=0.
REQ-015 Per-edge priority SHALL be: Reset > Load > count step > hold.
REQ-016 On a count step (Tick=1), Q SHALL update on that same rising edge.
REQ-017 Up step: ones 0..8 -> +1; ones 9 -> ones 0 and tens +1; Q=0x99 -> 0x00.
REQ-018 Down step: ones 1..9 -> -1; ones 0 -> ones 9 and tens -1; Q=0x00 -> 0x99.
REQ-019 Wrap SHALL be registered: high for exactly the one cycle following the edge on which the 99->00 or 00->99 transition occurred; otherwise low.
REQ-020 Load with D[7:4]<=9 and D[3:0]<=9: Q SHALL take D on that edge and LoadErr SHALL clear to 0.
REQ-021 Load with either nibble >9: Q SHALL hold and LoadErr SHALL set to 1.
REQ-022 Any Load, valid or not, SHALL clear the prescaler to 0 and SHALL suppress the step for that cycle.
REQ-023 LoadErr SHALL remain set until the next valid load or reset.
REQ-024 Wrap SHALL be 0 in the cycle following any load.
REQ-025 Q SHALL never hold a nibble value above 9 under any input sequence.
REQ-026 Changing Up between steps SHALL take effect on the next step only; the prescaler phase is unaffected.
REQ-027 Deasserting En mid-period SHALL freeze the prescaler; reasserting resumes from the frozen value.

Reset
REQ-028 On a Reset edge: Q=0x00, prescaler=0, Wrap=0, LoadErr=0, regardless of En, Load or D.
REQ-029 Reset asserted mid-period SHALL discard the partial prescaler count; the first step after release occurs TICK_DIV enabled cycles later.
REQ-030 Tick SHALL be 0 while Reset=1.

Verification (TICK_DIV=4 unless stated)
REQ-031 Reset, En=1, Up=1, 40 cycles -> Tick every 4th cycle; Q steps 00,01,..,09,10; ones 9 -> tens carry verified.
REQ-032 Load D=0x98, Up=1, 2 steps -> Q=0x99 then 0x00; Wrap high exactly one cycle after the 99->00 edge.
REQ-033 Load D=0x00, Up=0, 1 step -> Q=0x99 and Wrap pulse; the next step gives Q=0x98 with Wrap=0.
REQ-034 Q=0x42, Load D=0x4A -> Q stays 0x42 and LoadErr=1; then Load D=0x37 -> Q=0x37 and LoadErr=0.
REQ-035 Load asserted on the same cycle as the prescaler terminal count -> no step, Q=D, and the next Tick occurs 4 enabled cycles later.
REQ-036 TICK_DIV=1, En toggled 1,0,1 with Reset pulsed mid-run -> Q increments only on En=1 cycles, reads 0x00 after the Reset edge, and no Tick occurs during Reset.
